// File: rtl/snake_pkg.sv
// Shared codes for the snake game datapath: game states, directions,
// button encodings and step-sequencer phases.
package snake_pkg;

  localparam logic [1:0] GS_INIT = 2'd0;
  localparam logic [1:0] GS_RUN  = 2'd1;
  localparam logic [1:0] GS_STOP = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [3:0] BTN_UP    = 4'b0001;
  localparam logic [3:0] BTN_DOWN  = 4'b0010;
  localparam logic [3:0] BTN_LEFT  = 4'b0100;
  localparam logic [3:0] BTN_RIGHT = 4'b1000;

  localparam logic [15:0] STEP_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_WAIT_TICK  = 3'd1,
    PH_LATCH_DIR  = 3'd2,
    PH_LOGIC_REQ  = 3'd3,
    PH_LOGIC_WAIT = 3'd4,
    PH_PRNG_REQ   = 3'd5,
    PH_PRNG_WAIT  = 3'd6,
    PH_DEAD       = 3'd7
  } phase_t;

  function automatic logic [1:0] dir_opposite(
    input logic [1:0] d
  );
    logic [1:0] o;
    unique case (d)
      DIR_UP:   o = DIR_DOWN;
      DIR_DOWN: o = DIR_UP;
      DIR_LEFT: o = DIR_RIGHT;
      default:  o = DIR_LEFT;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] btn_to_dir(
    input logic [3:0] b
  );
    logic [1:0] d;
    case (b)
      BTN_UP:   d = DIR_UP;
      BTN_DOWN: d = DIR_DOWN;
      BTN_LEFT: d = DIR_LEFT;
      default:  d = DIR_RIGHT;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/step_sequencer_tick_div.sv
// Game tick divider: counts up to TICK_DIV-1 and parks there until
// the sequencer clears it, so a pending tick is never lost or doubled.
module step_tick_div #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic clka,
  input  logic restart,
  input  logic run,
  input  logic clear,
  output logic tick_pending
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_pending = (cnt == LAST);

endmodule

// File: rtl/step_sequencer.sv
// One snake step per game tick: direction latch, logic/PRNG handshakes,
// step counter and collision latch.
module step_sequencer
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic        clka,
  input  logic        restart,
  input  logic [1:0]  game_state,
  input  logic [3:0]  direction_in,
  input  logic        logic_done,
  input  logic        logic_dead,
  input  logic        logic_ate,
  input  logic        prng_done,
  output logic [1:0]  direction_state,
  output logic        logic_start,
  output logic        prng_start,
  output logic [2:0]  execution_state,
  output logic [15:0] step_count,
  output logic        game_over
);

  phase_t phase;
  phase_t phase_nx;

  logic run_gs;
  logic active;
  logic in_step;
  logic abort;
  logic tick_pending;
  logic tick_run;
  logic tick_clear;
  logic press_ok;
  logic [1:0] press_dir;
  logic dir_buf_vld;
  logic [1:0] dir_buf;
  logic game_reset;
  logic [1:0] dir_nx;
  logic [15:0] step_nx;
  logic over_nx;
  logic lstart_nx;
  logic pstart_nx;

  assign run_gs  = (game_state == GS_RUN);
  assign active  = (phase != PH_IDLE) && (phase != PH_DEAD);
  assign in_step = active && (phase != PH_WAIT_TICK);
  assign abort   = active && !run_gs;

  // Count restarts only once the step is finished.
  assign tick_run   = active && run_gs;
  assign tick_clear = !active || abort ||
                      (in_step && phase_nx == PH_WAIT_TICK);

  assign press_dir = btn_to_dir(direction_in);
  assign press_ok  = $onehot(direction_in) &&
                     (press_dir != dir_opposite(direction_state));

  assign game_reset = !active && (game_state == GS_INIT);
  assign execution_state = phase;

  step_tick_div #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clka         (clka),
    .restart      (restart),
    .run          (tick_run),
    .clear        (tick_clear),
    .tick_pending (tick_pending)
  );

  always_ff @(posedge clka or posedge restart) begin
    if (restart) phase <= PH_IDLE;
    else         phase <= phase_nx;
  end

  always_comb begin
    phase_nx = phase;
    if (abort) begin
      phase_nx = PH_IDLE;
    end else begin
      unique case (phase)
        PH_IDLE:
          if (run_gs) phase_nx = PH_WAIT_TICK;
        PH_WAIT_TICK:
          if (tick_pending) phase_nx = PH_LATCH_DIR;
        PH_LATCH_DIR:
          phase_nx = PH_LOGIC_REQ;
        PH_LOGIC_REQ:
          phase_nx = PH_LOGIC_WAIT;
        PH_LOGIC_WAIT:
          if (logic_done) begin
            if (logic_dead)     phase_nx = PH_DEAD;
            else if (logic_ate) phase_nx = PH_PRNG_REQ;
            else                phase_nx = PH_WAIT_TICK;
          end
        PH_PRNG_REQ:
          phase_nx = PH_PRNG_WAIT;
        PH_PRNG_WAIT:
          if (prng_done) phase_nx = PH_WAIT_TICK;
        PH_DEAD:
          if (game_state == GS_INIT) phase_nx = PH_IDLE;
        default:
          phase_nx = PH_IDLE;
      endcase
    end
  end

  always_comb begin
    dir_nx    = direction_state;
    step_nx   = step_count;
    over_nx   = game_over;
    lstart_nx = (phase_nx == PH_LOGIC_REQ);
    pstart_nx = (phase_nx == PH_PRNG_REQ);
    if (game_reset) begin
      dir_nx  = DIR_RIGHT;
      step_nx = '0;
      over_nx = 1'b0;
    end else begin
      // A press in the tick cycle itself still counts for this step.
      if (phase_nx == PH_LATCH_DIR) begin
        if (dir_buf_vld)   dir_nx = dir_buf;
        else if (press_ok) dir_nx = press_dir;
        if (step_count != STEP_MAX) step_nx = step_count + 16'd1;
      end
      if (phase_nx == PH_DEAD) over_nx = 1'b1;
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      direction_state <= DIR_RIGHT;
      step_count      <= '0;
      game_over       <= 1'b0;
      logic_start     <= 1'b0;
      prng_start      <= 1'b0;
      dir_buf_vld     <= 1'b0;
      dir_buf         <= DIR_RIGHT;
    end else begin
      direction_state <= dir_nx;
      step_count      <= step_nx;
      game_over       <= over_nx;
      logic_start     <= lstart_nx;
      prng_start      <= pstart_nx;
      if (!active || abort) begin
        dir_buf_vld <= 1'b0;
      end else if (phase == PH_LATCH_DIR) begin
        dir_buf_vld <= press_ok;
        dir_buf     <= press_dir;
      end else if (!dir_buf_vld && press_ok) begin
        dir_buf_vld <= 1'b1;
        dir_buf     <= press_dir;
      end
    end
  end

endmodule
